register_file_mp: RTL and testbench

- Parametrised multi-port successor to the single-cycle MIPS RegisterFile.
- Provides NUM_RD asynchronous read ports and two write ports, with per-byte write enables and optional read-during-write bypass.
- Register 0 can be configured as hardwired zero.
- Sits in the decode stage of the single-cycle and upcoming dual-issue datapaths.

---
 rtl/register_file_mp_pkg.sv | 33 +++
 rtl/register_file_mp_if.sv | 36 +++
 rtl/register_file_mp_read_port.sv | 59 +++++
 rtl/register_file_mp.sv | 92 +++++++++
 tb/tb_register_file_mp.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared constants and the port-1-priority byte merge used by both the
// register write path and the read-port bypass path.
package regfile_pkg;

    // Widest register the shared merge helper supports; callers zero-extend.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    function automatic int bytesOf(input int dataW);
        return dataW / 8;
    endfunction

    // Port 1 wins any byte enabled on both ports; unenabled bytes keep oldVal.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] oldVal,
        input logic [MAX_DATA_W-1:0] d0,
        input logic [MAX_BYTES-1:0]  en0,
        input logic [MAX_DATA_W-1:0] d1,
        input logic [MAX_BYTES-1:0]  en1
    );
        logic [MAX_DATA_W-1:0] res;
        res = oldVal;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (en1[i]) begin
                res[8*i +: 8] = d1[8*i +: 8];
            end else if (en0[i]) begin
                res[8*i +: 8] = d0[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between the decode stage (master) and the multi-port register
// file (slave): read address/data vectors plus two byte-enabled write ports.
interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    localparam int BYTES = DATA_W / 8;

    logic [NUM_RD*ADDR_W-1:0] RA;
    logic [NUM_RD*DATA_W-1:0] BusR;

    logic [ADDR_W-1:0] RW0;
    logic [DATA_W-1:0] BusW0;
    logic              RegWr0;
    logic [BYTES-1:0]  ByteEn0;

    logic [ADDR_W-1:0] RW1;
    logic [DATA_W-1:0] BusW1;
    logic              RegWr1;
    logic [BYTES-1:0]  ByteEn1;

    modport master (
        output RA,
        output RW0, BusW0, RegWr0, ByteEn0,
        output RW1, BusW1, RegWr1, ByteEn1,
        input  BusR
    );

    modport slave (
        input  RA,
        input  RW0, BusW0, RegWr0, ByteEn0,
        input  RW1, BusW1, RegWr1, ByteEn1,
        output BusR
    );
endinterface

// File: rtl/register_file_mp_read_port.sv
// One combinational read port: address mux, optional same-cycle write
// forwarding, and hardwired-zero forcing for register 0.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic                                 Rst_n,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic [ADDR_W-1:0]                    RA,
    input  logic [ADDR_W-1:0]                    RW0,
    input  logic [DATA_W-1:0]                    BusW0,
    input  logic                                 RegWr0,
    input  logic [DATA_W/8-1:0]                  ByteEn0,
    input  logic [ADDR_W-1:0]                    RW1,
    input  logic [DATA_W-1:0]                    BusW1,
    input  logic                                 RegWr1,
    input  logic [DATA_W/8-1:0]                  ByteEn1,
    output logic [DATA_W-1:0]                    BusR
);
    localparam int BYTES = bytesOf(DATA_W);

    function automatic logic [DATA_W-1:0] mergeW(
        input logic [DATA_W-1:0] oldVal,
        input logic [DATA_W-1:0] d0,
        input logic [BYTES-1:0]  e0,
        input logic [DATA_W-1:0] d1,
        input logic [BYTES-1:0]  e1
    );
        return DATA_W'(merge_bytes(MAX_DATA_W'(oldVal), MAX_DATA_W'(d0), MAX_BYTES'(e0),
                                   MAX_DATA_W'(d1), MAX_BYTES'(e1)));
    endfunction

    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] rdVal;

    always_comb begin
        hit0  = 1'b0;
        hit1  = 1'b0;
        rdVal = regs[RA];
        // Forwarding is gated by reset so reads stay zero while writes are suppressed.
        if (BYPASS != 0 && Rst_n) begin
            hit0 = RegWr0 && (RW0 == RA);
            hit1 = RegWr1 && (RW1 == RA);
        end
        if (hit0 || hit1) begin
            rdVal = mergeW(rdVal, BusW0, hit0 ? ByteEn0 : '0, BusW1, hit1 ? ByteEn1 : '0);
        end
        if (ZERO_REG != 0 && RA == '0) begin
            rdVal = '0;
        end
        BusR = rdVal;
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port MIPS register file: NUM_RD async read ports, two byte-enabled
// write ports committing on the falling edge, optional zero register/bypass.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic                Clk,
    input  logic                Rst_n,
    register_file_mp_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int BYTES = bytesOf(DATA_W);

    if (DATA_W % 8 != 0 || DATA_W > MAX_DATA_W) begin : gBadDataW
        $error("register_file_mp: DATA_W must be a multiple of 8 and at most MAX_DATA_W");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : gBadNumRd
        $error("register_file_mp: NUM_RD must be in 1..4");
    end

    function automatic logic [DATA_W-1:0] mergeW(
        input logic [DATA_W-1:0] oldVal,
        input logic [DATA_W-1:0] d0,
        input logic [BYTES-1:0]  e0,
        input logic [DATA_W-1:0] d1,
        input logic [BYTES-1:0]  e1
    );
        return DATA_W'(merge_bytes(MAX_DATA_W'(oldVal), MAX_DATA_W'(d0), MAX_BYTES'(e0),
                                   MAX_DATA_W'(d1), MAX_BYTES'(e1)));
    endfunction

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic                         sameAddr;
    logic                         wrOk0;
    logic                         wrOk1;
    logic [DATA_W-1:0]            wrVal0;
    logic [DATA_W-1:0]            wrVal1;

    // On a collision both ports compute the same merged word, so the order of
    // the two stores below does not matter.
    always_comb begin
        sameAddr = (bus.RW0 == bus.RW1);
        wrOk0    = bus.RegWr0 && !(ZERO_REG != 0 && bus.RW0 == '0);
        wrOk1    = bus.RegWr1 && !(ZERO_REG != 0 && bus.RW1 == '0);
        wrVal0   = mergeW(regs[bus.RW0], bus.BusW0, bus.ByteEn0, bus.BusW1,
                          (bus.RegWr1 && sameAddr) ? bus.ByteEn1 : '0);
        wrVal1   = mergeW(regs[bus.RW1], bus.BusW0,
                          (bus.RegWr0 && sameAddr) ? bus.ByteEn0 : '0,
                          bus.BusW1, bus.ByteEn1);
    end

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regs <= '0;
        end else begin
            if (wrOk0) begin
                regs[bus.RW0] <= wrVal0;
            end
            if (wrOk1) begin
                regs[bus.RW1] <= wrVal1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) uRd (
            .Rst_n  (Rst_n),
            .regs   (regs),
            .RA     (bus.RA[k*ADDR_W +: ADDR_W]),
            .RW0    (bus.RW0),
            .BusW0  (bus.BusW0),
            .RegWr0 (bus.RegWr0),
            .ByteEn0(bus.ByteEn0),
            .RW1    (bus.RW1),
            .BusW1  (bus.BusW1),
            .RegWr1 (bus.RegWr1),
            .ByteEn1(bus.ByteEn1),
            .BusR   (bus.BusR[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: dut0 (zero reg, no bypass) and dut1
// (no zero reg, bypass) share one stimulus stream.
module tb_register_file_mp;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    logic [4:0]  ra0, ra1, rw0, rw1;
    logic [31:0] busW0, busW1;
    logic        wr0, wr1;
    logic [3:0]  be0, be1;

    register_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifc0 ();
    register_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifc1 ();

    assign ifc0.RA = {ra1, ra0};
    assign ifc0.RW0 = rw0;  assign ifc0.BusW0 = busW0; assign ifc0.RegWr0 = wr0; assign ifc0.ByteEn0 = be0;
    assign ifc0.RW1 = rw1;  assign ifc0.BusW1 = busW1; assign ifc0.RegWr1 = wr1; assign ifc0.ByteEn1 = be1;
    assign ifc1.RA = {ra1, ra0};
    assign ifc1.RW0 = rw0;  assign ifc1.BusW0 = busW0; assign ifc1.RegWr0 = wr0; assign ifc1.ByteEn0 = be0;
    assign ifc1.RW1 = rw1;  assign ifc1.BusW1 = busW1; assign ifc1.RegWr1 = wr1; assign ifc1.ByteEn1 = be1;

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(ifc0.slave));
    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(ifc1.slave));

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic idleWrites();
        wr0 = 1'b0; wr1 = 1'b0; be0 = 4'h0; be1 = 4'h0;
    endtask

    typedef struct packed {
        logic        wr0;
        logic [4:0]  rw0;
        logic [31:0] d0;
        logic [3:0]  e0;
        logic        wr1;
        logic [4:0]  rw1;
        logic [31:0] d1;
        logic [3:0]  e1;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] x0;
        logic [31:0] x1;
    } vec_t;

    vec_t vecs[10];

    typedef struct packed {
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] x0;
        logic [31:0] x1;
    } rd_t;

    rd_t rds[16];

    task automatic applyVec(input vec_t v, input int idx);
        @(posedge Clk); #1;
        wr0 = v.wr0; rw0 = v.rw0; busW0 = v.d0; be0 = v.e0;
        wr1 = v.wr1; rw1 = v.rw1; busW1 = v.d1; be1 = v.e1;
        ra0 = v.a0;  ra1 = v.a1;
        @(negedge Clk); #1;
        idleWrites();
        #1;
        check($sformatf("vec%0d.rd0", idx), ifc0.BusR[31:0],  v.x0);
        check($sformatf("vec%0d.rd1", idx), ifc0.BusR[63:32], v.x1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test vectors: {write port 0, write port 1, read addrs, expected reads on dut0}
        vecs[0] = '{1'b1, 5'd0,  32'h12345678, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd1,  32'h0,        32'h1};
        vecs[1] = '{1'b1, 5'd3,  32'hAABBCCDD, 4'h5, 1'b0, 5'd0,  32'h0,        4'h0, 5'd3,  5'd2,  32'h00BB00DD, 32'h2};
        vecs[2] = '{1'b1, 5'd7,  32'h11111111, 4'hF, 1'b1, 5'd7,  32'h22222222, 4'h3, 5'd7,  5'd6,  32'h11112222, 32'h6};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd8,  32'hA5A5A5A5, 4'h8, 5'd8,  5'd9,  32'hA5000008, 32'h9};
        vecs[4] = '{1'b1, 5'd10, 32'hABCD0000, 4'hC, 1'b1, 5'd11, 32'h0000BEEF, 4'h3, 5'd10, 5'd11, 32'hABCD000A, 32'h0000BEEF};
        vecs[5] = '{1'b1, 5'd12, 32'h01020304, 4'h9, 1'b1, 5'd12, 32'hF0F0F0F0, 4'h6, 5'd12, 5'd13, 32'h01F0F004, 32'hD};
        vecs[6] = '{1'b1, 5'd13, 32'h33333333, 4'hF, 1'b1, 5'd13, 32'h44444444, 4'hF, 5'd13, 5'd12, 32'h44444444, 32'h01F0F004};
        vecs[7] = '{1'b0, 5'd14, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd14, 5'd0,  32'hE,        32'h0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd15, 32'hFFFFFFFF, 4'h0, 5'd15, 5'd3,  32'hF,        32'h00BB00DD};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd0,  32'h87654321, 4'hF, 5'd0,  5'd7,  32'h0,        32'h11112222};
        for (int i = 0; i < 15; i++) begin
            rds[i] = '{5'(2*i+1), 5'(2*i+2), 32'(2*i+1), 32'(2*i+2)};
        end
        rds[15] = '{5'd31, 5'd0, 32'd31, 32'd0};

        // Reset held: a write is suppressed and all reads are zero
        Rst_n = 1'b0;
        idleWrites();
        rw0 = 5'd5; busW0 = 32'hDEADBEEF; be0 = 4'hF; wr0 = 1'b1;
        rw1 = 5'd0; busW1 = 32'h0;
        ra0 = 5'd5; ra1 = 5'd0;
        @(negedge Clk); #1;
        check("rst.dut0.rd0", ifc0.BusR[31:0],  32'h0);
        check("rst.dut0.rd1", ifc0.BusR[63:32], 32'h0);
        check("rst.dut1.rd0", ifc1.BusR[31:0],  32'h0);
        idleWrites();
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(negedge Clk); #1;
        check("rst.after.dut0.r5", ifc0.BusR[31:0], 32'h0);
        check("rst.after.dut1.r5", ifc1.BusR[31:0], 32'h0);

        // Fill registers 1..31 with their index, odd on port 0, even on port 1
        for (int r = 1; r <= 31; r += 2) begin
            @(posedge Clk); #1;
            wr0 = 1'b1; rw0 = 5'(r); busW0 = 32'(r); be0 = 4'hF;
            if (r < 31) begin
                wr1 = 1'b1; rw1 = 5'(r + 1); busW1 = 32'(r + 1); be1 = 4'hF;
            end
            @(negedge Clk); #1;
            idleWrites();
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge Clk); #1;
            ra0 = rds[i].a0; ra1 = rds[i].a1;
            #1;
            check($sformatf("fill%0d.dut0.rd0", i), ifc0.BusR[31:0],  rds[i].x0);
            check($sformatf("fill%0d.dut0.rd1", i), ifc0.BusR[63:32], rds[i].x1);
            check($sformatf("fill%0d.dut1.rd0", i), ifc1.BusR[31:0],  rds[i].x0);
            check($sformatf("fill%0d.dut1.rd1", i), ifc1.BusR[63:32], rds[i].x1);
        end

        for (int i = 0; i < 10; i++) begin
            applyVec(vecs[i], i);
        end

        // Register 0 is ordinary storage when not hardwired
        @(posedge Clk); #1;
        ra0 = 5'd0;
        #1;
        check("zreg.dut0", ifc0.BusR[31:0], 32'h0);
        check("zreg.dut1", ifc1.BusR[31:0], 32'h87654321);

        // Bypass: forwarded value visible before the committing edge
        @(posedge Clk); #1;
        wr0 = 1'b1; rw0 = 5'd9; busW0 = 32'hCAFEF00D; be0 = 4'hF;
        ra0 = 5'd9; ra1 = 5'd17;
        #1;
        check("byp.dut1.pre",   ifc1.BusR[31:0],  32'hCAFEF00D);
        check("byp.dut0.pre",   ifc0.BusR[31:0],  32'h9);
        check("byp.dut1.other", ifc1.BusR[63:32], 32'h11);
        @(negedge Clk); #1;
        check("byp.dut0.post", ifc0.BusR[31:0], 32'hCAFEF00D);
        check("byp.dut1.post", ifc1.BusR[31:0], 32'hCAFEF00D);
        idleWrites();

        // Bypass of a colliding write uses the port-1-priority merge
        @(posedge Clk); #1;
        wr0 = 1'b1; rw0 = 5'd16; busW0 = 32'hAAAAAAAA; be0 = 4'hF;
        wr1 = 1'b1; rw1 = 5'd16; busW1 = 32'h55555555; be1 = 4'h1;
        ra0 = 5'd16;
        #1;
        check("bypc.dut1.pre", ifc1.BusR[31:0], 32'hAAAAAA55);
        check("bypc.dut0.pre", ifc0.BusR[31:0], 32'h10);
        @(negedge Clk); #1;
        idleWrites();
        #1;
        check("bypc.dut0.post", ifc0.BusR[31:0], 32'hAAAAAA55);

        // No forwarding when the write enable is low
        @(posedge Clk); #1;
        wr0 = 1'b0; rw0 = 5'd17; busW0 = 32'hFFFFFFFF; be0 = 4'hF;
        ra0 = 5'd17;
        #1;
        check("byp.nowr.dut1", ifc1.BusR[31:0], 32'h11);
        idleWrites();

        // Reset pulse mid-cycle clears everything immediately
        @(posedge Clk); #1;
        wr0 = 1'b1; rw0 = 5'd4; busW0 = 32'h44; be0 = 4'hF;
        @(negedge Clk); #1;
        idleWrites();
        ra0 = 5'd4; ra1 = 5'd9;
        #1;
        check("rmid.r4.before", ifc0.BusR[31:0], 32'h44);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        #1;
        check("rmid.dut0.r4", ifc0.BusR[31:0],  32'h0);
        check("rmid.dut0.r9", ifc0.BusR[63:32], 32'h0);
        check("rmid.dut1.r4", ifc1.BusR[31:0],  32'h0);
        #2;
        Rst_n = 1'b1;
        rw0 = 5'd4; busW0 = 32'hFFFFFFFF; be0 = 4'hF; wr0 = 1'b0;
        @(negedge Clk); #1;
        check("rmid.after.dut0", ifc0.BusR[31:0], 32'h0);
        check("rmid.after.dut1", ifc1.BusR[31:0], 32'h0);

        // A write arriving while reset is still low is lost
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        wr0 = 1'b1; rw0 = 5'd20; busW0 = 32'h12; be0 = 4'hF;
        ra0 = 5'd20;
        @(negedge Clk); #1;
        check("rlost.during", ifc0.BusR[31:0], 32'h0);
        idleWrites();
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(negedge Clk); #1;
        check("rlost.after", ifc0.BusR[31:0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
